// File: rtl/adder_pkg.sv
// Shared constants and the 4-wide lookahead group function for the adder.
// Reused by the 4-bit group cells and by the lookahead level above them.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 32;
  localparam int GROUP_W             = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Group propagate/generate over four propagate/generate pairs; bit 0 is the least significant.
  function automatic pg_t group_pg(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g);
    pg_t r;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead group: sum bits, group P/G and the carry out of bit 2.
// The bit-2 carry lets the top group form the signed overflow flag.
module cla4
  import adder_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] sum_o,
  output logic       gp_o,
  output logic       gg_o,
  output logic       c2_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  pg_t        grp;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = ci_i;
    c[1] = g[0] | (p[0] & ci_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
    grp  = group_pg(p, g);
  end

  assign sum_o = p ^ c;
  assign gp_o  = grp.p;
  assign gg_o  = grp.g;
  assign c2_o  = c[3];

endmodule

// File: rtl/adder.sv
// Registered two-level carry-lookahead adder with carry-out and signed overflow.
// ADDER_IN_REG_EN adds an input register stage (latency 2 instead of 1).
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int NG = WIDTH / GROUP_W;
  localparam int NS = (NG + 3) / 4;
  localparam int NP = NS * 4;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("adder: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef ADDER_IN_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  logic [WIDTH-1:0] raw_sum;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_c2;
  logic [NP-1:0]    pad_p;
  logic [NP-1:0]    pad_g;
  logic [NP-1:0]    grp_ci;
  logic             carry_out;
  logic             unused_lo_c2;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4 u_cla4 (
      .a_i  (op_a[4*k +: 4]),
      .b_i  (op_b[4*k +: 4]),
      .ci_i (grp_ci[k]),
      .sum_o(raw_sum[4*k +: 4]),
      .gp_o (grp_p[k]),
      .gg_o (grp_g[k]),
      .c2_o (grp_c2[k])
    );
  end

  // Second lookahead level: groups are bundled four at a time; padding groups propagate.
  always_comb begin
    logic sc;
    pg_t  blk;
    pad_p          = '1;
    pad_g          = '0;
    pad_p[NG-1:0]  = grp_p;
    pad_g[NG-1:0]  = grp_g;
    grp_ci         = '0;
    sc             = op_cin;
    blk            = '0;
    for (int s = 0; s < NS; s++) begin
      blk             = group_pg(pad_p[4*s +: 4], pad_g[4*s +: 4]);
      grp_ci[4*s]     = sc;
      grp_ci[4*s + 1] = pad_g[4*s] | (pad_p[4*s] & sc);
      grp_ci[4*s + 2] = pad_g[4*s + 1] | (pad_p[4*s + 1] & pad_g[4*s])
                      | (pad_p[4*s + 1] & pad_p[4*s] & sc);
      grp_ci[4*s + 3] = pad_g[4*s + 2] | (pad_p[4*s + 2] & pad_g[4*s + 1])
                      | (pad_p[4*s + 2] & pad_p[4*s + 1] & pad_g[4*s])
                      | (pad_p[4*s + 2] & pad_p[4*s + 1] & pad_p[4*s] & sc);
      sc              = blk.g | (blk.p & sc);
    end
    carry_out = sc;
  end

  assign unused_lo_c2 = ^grp_c2[NG-2:0];

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             of_q, of_d;

  always_comb begin
    sum_d  = raw_sum;
    cout_d = carry_out;
    // Overflow: carry into the MSB differs from carry out of it.
    of_d   = grp_c2[NG-1] ^ carry_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      of_q   <= of_d;
    end
  end

  // No handshake: sum/cout/of are valid every cycle once the pipeline latency has elapsed.
  assign sum  = sum_q;
  assign cout = cout_q;
  assign of   = of_q;

endmodule

// File: tb/tb_adder.sv
// Directed-vector bench for adder; expected values are hand-computed constants.
// Honours ADDER_IN_REG_EN by switching the expected latency to 2.
module tb_adder;

  localparam int W = 32;
`ifdef ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         of_o;

  always #5 clk = ~clk;

  adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a_i),
    .b   (b_i),
    .cin (cin_i),
    .sum (sum_o),
    .cout(cout_o),
    .of  (of_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Scoreboard entry layout: {sum, cout, of}
  logic [W+1:0] exp_q[$];

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_i   = a;
    b_i   = b;
    cin_i = c;
  endtask

  task automatic check(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    n_vec++;
    assert (sum_o === es && cout_o === ec && of_o === eo) else begin
      n_bad++;
      $error("FAIL %s: got sum=%h cout=%b of=%b, expected sum=%h cout=%b of=%b",
             tag, sum_o, cout_o, of_o, es, ec, eo);
    end
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    drive(a, b, c);
    repeat (LAT) step();
    check(tag, es, ec, eo);
  endtask

  // Back-to-back table
  logic [W-1:0] bb_a  [6];
  logic [W-1:0] bb_b  [6];
  logic         bb_c  [6];
  logic [W+1:0] bb_exp[6];

  initial begin
    logic [W+1:0] e;

    bb_a[0] = 32'h0000_0001; bb_b[0] = 32'h0000_0002; bb_c[0] = 1'b0; bb_exp[0] = {32'h0000_0003, 1'b0, 1'b0};
    bb_a[1] = 32'h7FFF_FFFF; bb_b[1] = 32'h0000_0001; bb_c[1] = 1'b0; bb_exp[1] = {32'h8000_0000, 1'b0, 1'b1};
    bb_a[2] = 32'hFFFF_FFFF; bb_b[2] = 32'h0000_0000; bb_c[2] = 1'b1; bb_exp[2] = {32'h0000_0000, 1'b1, 1'b0};
    bb_a[3] = 32'h8000_0000; bb_b[3] = 32'h8000_0000; bb_c[3] = 1'b0; bb_exp[3] = {32'h0000_0000, 1'b1, 1'b1};
    bb_a[4] = 32'h0F0F_0F0F; bb_b[4] = 32'hF0F0_F0F0; bb_c[4] = 1'b1; bb_exp[4] = {32'h0000_0000, 1'b1, 1'b0};
    bb_a[5] = 32'h1234_5678; bb_b[5] = 32'h1111_1111; bb_c[5] = 1'b1; bb_exp[5] = {32'h2345_678A, 1'b0, 1'b0};

    // Reset with overflowing operands on the bus: outputs must be zero.
    rst = 1'b1;
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    step();
    step();
    check("reset_state", 32'h0, 1'b0, 1'b0);

    // First result after release
    rst = 1'b0;
    drive(32'h0000_0420, 32'h0000_0420, 1'b1);
    step();
    if (LAT == 2) begin
      check("release_gap", 32'h0, 1'b0, 1'b0);
      step();
    end
    check("release_first", 32'h0000_0841, 1'b0, 1'b0);

    // Directed vectors
    run_vec("pos_pos_of",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run_vec("neg_neg_of",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_vec("mixed_sign",   32'h1234_5678, 32'h8000_0000, 1'b0, 32'h9234_5678, 1'b0, 1'b0);
    run_vec("pos_pos_cin",  32'h1234_5678, 32'h1234_5670, 1'b1, 32'h2468_ACE9, 1'b0, 1'b0);
    run_vec("neg_neg_nof",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_vec("small_cin",    32'h0000_0420, 32'h0000_0420, 1'b1, 32'h0000_0841, 1'b0, 1'b0);
    run_vec("neg_pos",      32'hFFFF_F999, 32'h0000_0111, 1'b0, 32'hFFFF_FAAA, 1'b0, 1'b0);
    run_vec("cin_only",     32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    run_vec("cin_wrap",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("cin_of",       32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    run_vec("group_ripple", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Back-to-back operands, one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(bb_a[i], bb_b[i], bb_c[i]);
      exp_q.push_back(bb_exp[i]);
      step();
      if (i >= LAT - 1) begin
        e = exp_q.pop_front();
        check("back_to_back", e[W+1:2], e[1], e[0]);
      end
    end
    for (int i = 0; i < LAT - 1; i++) begin
      step();
      e = exp_q.pop_front();
      check("back_to_back_drain", e[W+1:2], e[1], e[0]);
    end

    // Mid-stream reset: an in-flight result must not reappear afterwards.
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    step();
    rst = 1'b1;
    step();
    check("midstream_reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(32'h0000_0005, 32'h0000_0007, 1'b0);
    step();
    if (LAT == 2) begin
      check("post_reset_no_stale", 32'h0, 1'b0, 1'b0);
      step();
    end
    check("post_reset_first", 32'h0000_000C, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
